// File: rtl/frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : frame_fifo
// Description : Frame-granular FIFO with val/rdy handshakes on both sides.
//               Holds up to DEPTH frames of N_SAMPLES x BIT_WIDTH samples.
//               recv_rdy depends only on registered occupancy, so there is
//               no combinational path from send_rdy to recv_rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_fifo #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8,
   parameter int DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      recv_val,
   output logic                      recv_rdy,
   input  logic [BIT_WIDTH-1:0]      recv_msg [N_SAMPLES-1:0],
   output logic                      send_val,
   input  logic                      send_rdy,
   output logic [BIT_WIDTH-1:0]      send_msg [N_SAMPLES-1:0],
   output logic [$clog2(DEPTH):0]    count
);

   localparam int                   c_PTR_W   = $clog2(DEPTH);
   localparam int                   c_CNT_W   = c_PTR_W + 1;
   localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0]   c_FULL    = c_CNT_W'(DEPTH);

   // Frame storage; intentionally not reset, contents are qualified by count.
   logic [BIT_WIDTH-1:0] r_mem [DEPTH-1:0][N_SAMPLES-1:0];

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic w_enq;
   logic w_deq;

   // Handshake status comes straight from registered occupancy.
   assign recv_rdy = (r_count != c_FULL);
   assign send_val = (r_count != '0);
   assign count    = r_count;

   assign w_enq = recv_val & recv_rdy;
   assign w_deq = send_val & send_rdy;

   // Head frame is read combinationally from storage at the read pointer.
   for (genvar i = 0; i < N_SAMPLES; i++) begin : g_out
      assign send_msg[i] = r_mem[r_rd_ptr][i];
   end

   // Capture the incoming frame at the write pointer on every accepted transfer.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wr_ptr] <= recv_msg;
      end
   end

   // Pointer and occupancy update; a simultaneous enq and deq leaves count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_fifo
// Description : Directed and randomised stimulus for frame_fifo with a
//               frame-level reference queue checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_fifo;

   localparam int BW    = 32;
   localparam int NS    = 8;
   localparam int DEPTH = 4;
   localparam int FW    = BW * NS;

   logic              clk = 1'b0;
   logic              reset;
   logic              recv_val;
   logic              recv_rdy;
   logic [BW-1:0]     recv_msg [NS-1:0];
   logic              send_val;
   logic              send_rdy;
   logic [BW-1:0]     send_msg [NS-1:0];
   logic [2:0]        count;

   logic [FW-1:0]     model_q [$];
   int                n_checks = 0;
   int                n_pass   = 0;

   frame_fifo #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .recv_msg (recv_msg),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .send_msg (send_msg),
      .count    (count)
   );

   always #5 clk = ~clk;

   function automatic logic [FW-1:0] mkframe(input logic [31:0] base);
      logic [FW-1:0] f;
      for (int j = 0; j < NS; j++) f[j*BW +: BW] = base + 32'(j);
      return f;
   endfunction

   function automatic logic [FW-1:0] packed_out();
      logic [FW-1:0] f;
      for (int j = 0; j < NS; j++) f[j*BW +: BW] = send_msg[j];
      return f;
   endfunction

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One clock of stimulus: drive, check outputs against the reference, then
   // advance the reference by whatever transfers the handshake allows.
   task automatic cycle(input logic rv, input logic [FW-1:0] msg, input logic sr,
                        output logic acc);
      logic exp_rdy, exp_val, deq;
      recv_val = rv;
      send_rdy = sr;
      for (int j = 0; j < NS; j++) recv_msg[j] = msg[j*BW +: BW];
      @(negedge clk);
      exp_rdy = (model_q.size() != DEPTH);
      exp_val = (model_q.size() != 0);
      check("recv_rdy", FW'(recv_rdy), FW'(exp_rdy));
      check("send_val", FW'(send_val), FW'(exp_val));
      check("count",    FW'(count),    FW'(model_q.size()));
      if (exp_val) check("send_msg", packed_out(), model_q[0]);
      acc = rv & exp_rdy;
      deq = exp_val & sr;
      @(posedge clk);
      #1;
      if (deq) void'(model_q.pop_front());
      if (acc) model_q.push_back(msg);
   endtask

   task automatic drain();
      logic acc;
      for (int k = 0; k < 20 && model_q.size() != 0; k++) cycle(1'b0, '0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, acc);
   endtask

   initial begin
      logic          acc;
      int            idx;
      int            sent;
      logic [FW-1:0] f5 [13];

      reset    = 1'b1;
      recv_val = 1'b0;
      send_rdy = 1'b0;
      for (int j = 0; j < NS; j++) recv_msg[j] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Idle after reset, then reset with three frames stored.
      for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0, acc);
      for (int k = 0; k < 3; k++) cycle(1'b1, mkframe(32'h1000_0000 + 32'(k << 8)), 1'b0, acc);
      recv_val = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("rst_count",    FW'(count),    FW'(0));
      check("rst_send_val", FW'(send_val), FW'(0));
      check("rst_recv_rdy", FW'(recv_rdy), FW'(1));
      model_q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single frame {7..0} held through ten stall cycles.
      cycle(1'b1, mkframe(32'd0), 1'b0, acc);
      for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b0, acc);
      drain();

      // Fill to capacity with A..E; E waits until the consumer starts.
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, mkframe(32'h0A00_0000 + 32'(idx << 8)), 1'b0, acc);
         if (acc) idx++;
      end
      check("full_accepted", FW'(count), FW'(DEPTH));
      while (idx < 5) begin
         cycle(1'b1, mkframe(32'h0A00_0000 + 32'(idx << 8)), 1'b1, acc);
         if (acc) idx++;
      end
      drain();

      // Steady state at occupancy two with one frame in and one out per cycle.
      cycle(1'b1, mkframe(32'hDEAD_0000), 1'b0, acc);
      cycle(1'b1, mkframe(32'hDEAD_0100), 1'b0, acc);
      for (int k = 2; k < 22; k++) cycle(1'b1, mkframe(32'hDEAD_0000 + 32'(k << 8)), 1'b1, acc);
      check("steady_count", FW'(count), FW'(2));
      drain();

      // Pointer wrap with random valid/ready stalls.
      for (int k = 0; k < 13; k++) begin
         for (int j = 0; j < NS; j++) f5[k][j*BW +: BW] = $urandom;
      end
      sent = 0;
      for (int c = 0; c < 2000 && (sent < 13 || model_q.size() != 0); c++) begin
         cycle((sent < 13) && ($urandom_range(0, 3) != 0),
               (sent < 13) ? f5[sent] : '0,
               $urandom_range(0, 2) != 0, acc);
         if (acc) sent++;
      end
      cycle(1'b0, '0, 1'b0, acc);
      check("wrap_final_count", FW'(count), FW'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
